ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. Decodes 11-bit PS/2 frames from the keyboard clock and data lines, checks the start, parity and stop bits, and aborts stalled frames with a watchdog. Good scancodes are buffered in a valid/ready FIFO. Sits between the board pins and the scancode consumer, and still exposes a last-code debug byte for logic-analyzer pins.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_input_filter.sv | 44 ++++
 rtl/ps2_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  function automatic int timeout_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Odd parity: data bits plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchroniser plus stability filter for one PS/2 line; idles high.
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          stable_cnt_r;
  logic                   synced_s;

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain, reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Filtered value follows only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout         <= 1'b1;
      stable_cnt_r <= '0;
    end else if (synced_s == dout) begin
      stable_cnt_r <= '0;
    end else if (stable_cnt_r == CW'(FILTER_LEN - 1)) begin
      dout         <= synced_s;
      stable_cnt_r <= '0;
    end else begin
      stable_cnt_r <= stable_cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with watchdog, error pulses and a
// valid/ready scancode FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 16_000_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_US  = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [7:0]                  code_data,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  last_code,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int TIMEOUT_CYCLES = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic clk_filt, data_filt, clk_prev_r, fall_edge_s;

  ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .din(ps2_clk), .dout(clk_filt)
  );

  ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .din(ps2_data), .dout(data_filt)
  );

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev_r <= 1'b1;
    end else begin
      clk_prev_r <= clk_filt;
    end
  end

  assign fall_edge_s = clk_prev_r & ~clk_filt;

  ps2_state_t    state_r, state_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          par_r, par_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          push_s, perr_s, ferr_s, par_ok_s;

  assign par_ok_s = odd_parity_ok(shift_r, par_r);

  // Frame FSM state, watchdog and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      timer_r    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      timer_r    <= timer_s;
      parity_err <= perr_s;
      frame_err  <= ferr_s;
    end
  end

  // Next-state logic; the watchdog abort takes priority over a coincident edge.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    par_s     = par_r;
    timer_s   = '0;
    push_s    = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    if ((state_r != IDLE) && (timer_r == TW'(TIMEOUT_CYCLES))) begin
      state_s = IDLE;
      ferr_s  = 1'b1;
    end else if (fall_edge_s) begin
      case (state_r)
        IDLE: begin
          if (data_filt == 1'b0) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
          end else begin
            ferr_s = 1'b1;
          end
        end
        DATA: begin
          shift_s   = {data_filt, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'(PS2_DATA_BITS - 1)) begin
            state_s = PARITY;
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          par_s   = data_filt;
          state_s = STOP;
        end
        STOP: begin
          state_s = IDLE;
          perr_s  = ~par_ok_s;
          ferr_s  = ~data_filt;
          push_s  = par_ok_s & data_filt;
        end
        default: state_s = IDLE;
      endcase
    end else if (state_r != IDLE) begin
      timer_s = timer_r + 1'b1;
    end else begin
      timer_s = '0;
    end
  end

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          pop_s, full_s, write_s, ovf_set_s;

  assign code_valid = (count_r != '0);
  assign code_data  = mem_r[rd_ptr_r];
  assign fifo_count = count_r;
  assign pop_s      = code_valid & code_ready;
  assign full_s     = (count_r == (AW + 1)'(FIFO_DEPTH));
  // A pop on the same cycle frees the slot, so a push into a full FIFO still lands.
  assign write_s    = push_s & (~full_s | pop_s);
  assign ovf_set_s  = push_s & full_s & ~pop_s;

  // FIFO storage, pointers, occupancy, last code and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      last_code <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        last_code <= shift_r;
      end
      if (ovf_set_s) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomized frames against a queue-based reference model.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TO      = (16_000_000 / 1_000_000) * 200;
  localparam int SLOW    = 640;
  localparam int FAST    = 40;
  localparam int LAT_TOL = 2 + 4 + 8;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, code_ready, clear_overflow;
  logic [7:0] code_data, last_code;
  logic       code_valid, parity_err, frame_err, overflow;
  logic [3:0] fifo_count;

  ps2_rx_fifo dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .fifo_count(fifo_count), .last_code(last_code), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int perr_seen = 0;
  int ferr_seen = 0;
  always @(negedge clk) begin
    if (parity_err === 1'b1) perr_seen <= perr_seen + 1;
    if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  int checks = 0;
  int errors = 0;
  int last_fall_cyc = 0;
  int guard, delay, npop;
  logic [7:0] q[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ovf = 1'b0;
  int exp_perr = 0;
  int exp_ferr = 0;
  logic [7:0] rc;
  logic rp, rs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] c);
    return ($countones(c) % 2) == 0;
  endfunction

  task automatic model_frame(input logic [7:0] c, input logic p, input logic s);
    logic par_ok;
    par_ok = (($countones(c) + int'(p)) % 2) == 1;
    if (!par_ok) exp_perr++;
    if (s !== 1'b1) exp_ferr++;
    if (par_ok && s === 1'b1) begin
      m_last = c;
      if (q.size() < DEPTH) q.push_back(c);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, fifo_count, q.size());
    check({tag, "_valid"}, code_valid, q.size() != 0);
    if (q.size() != 0) check({tag, "_head"}, code_data, q[0]);
    check({tag, "_last"}, last_code, m_last);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_perr"}, perr_seen, exp_perr);
    check({tag, "_ferr"}, ferr_seen, exp_ferr);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code_data"}, code_data, 0);
    check({tag, "_code_valid"}, code_valid, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_last_code"}, last_code, 0);
    check({tag, "_parity_err"}, parity_err, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_pop_valid"}, code_valid, 1);
    check({tag, "_pop_data"}, code_data, q[0]);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    void'(q.pop_front());
  endtask

  // Sends the first nbits of a frame; optionally pulses code_ready on the
  // cycle the last falling edge completes the frame inside the receiver.
  task automatic send_frame(input logic [7:0] c, input logic p, input logic s,
                            input int nbits, input int half, input bit pop_on_last);
    logic [10:0] frame;
    frame = {s, p, c, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (half) tick();
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (pop_on_last && i == nbits - 1) begin
        repeat (6) tick();
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        repeat (half - 7) tick();
      end else begin
        repeat (half) tick();
      end
      ps2_clk = 1'b1;
    end
    repeat (half) tick();
    ps2_data = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; code_ready = 1'b0; clear_overflow = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_state("post_reset");

    send_frame(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, SLOW, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b1);
    check_state("good_1c");

    pop_one("drain_1c");
    send_frame(8'h1C, 1'b1, 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
    model_frame(8'h1C, 1'b1, 1'b1);
    check_state("bad_parity");

    send_frame(8'h33, 1'b0, 1'b1, 4, FAST, 1'b0);
    guard = 0;
    while (frame_err !== 1'b1 && guard < TO + 2000) begin
      tick();
      guard++;
    end
    delay = cyc - last_fall_cyc;
    check("timeout_delay_in_window", (delay >= TO) && (delay <= TO + LAT_TOL), 1);
    exp_ferr++;
    repeat (10) tick();
    check_state("timeout");
    send_frame(8'hF0, good_par(8'hF0), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
    model_frame(8'hF0, good_par(8'hF0), 1'b1);
    check_state("after_timeout_f0");
    pop_one("drain_f0");

    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), good_par(8'(i)), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
      model_frame(8'(i), good_par(8'(i)), 1'b1);
    end
    check_state("fill9");
    check("fill9_count_is_depth", fifo_count, DEPTH);
    for (int i = 1; i <= 8; i++) pop_one("drain9");
    check_state("drained9");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    m_ovf = 1'b0;
    check_state("clear_ovf");

    code_ready = 1'b1;
    repeat (2) tick();
    code_ready = 1'b0;
    check_state("ready_while_empty");

    for (int i = 0; i < DEPTH; i++) begin
      rc = 8'($urandom);
      send_frame(rc, good_par(rc), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
      model_frame(rc, good_par(rc), 1'b1);
    end
    check_state("refill");
    rc = 8'($urandom);
    send_frame(rc, good_par(rc), 1'b1, PS2_FRAME_BITS, FAST, 1'b1);
    void'(q.pop_front());
    model_frame(rc, good_par(rc), 1'b1);
    check_state("full_push_pop");
    while (q.size() != 0) pop_one("drain_full");
    check_state("drained_full");

    for (int n = 0; n < 8; n++) begin
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) if (q.size() != 0) pop_one("rnd");
      rc = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~good_par(rc) : good_par(rc);
      rs = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      send_frame(rc, rp, rs, PS2_FRAME_BITS, FAST, 1'b0);
      model_frame(rc, rp, rs);
      check_state("rnd");
    end

    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (2) tick();
    ps2_clk = 1'b1;
    repeat (20) tick();
    ps2_data = 1'b1;
    repeat (20) tick();
    check_state("glitch");
    while (q.size() != 0) pop_one("pre_glitch_frame");
    send_frame(8'h3A, good_par(8'h3A), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
    model_frame(8'h3A, good_par(8'h3A), 1'b1);
    check_state("after_glitch");

    send_frame(8'h77, good_par(8'h77), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
    model_frame(8'h77, good_par(8'h77), 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 5, FAST, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    repeat (2) tick();
    rst = 1'b0;
    q.delete();
    m_last = 8'h00;
    m_ovf = 1'b0;
    repeat (5) tick();
    check_state("after_mid_reset");
    send_frame(8'h5A, good_par(8'h5A), 1'b1, PS2_FRAME_BITS, FAST, 1'b0);
    model_frame(8'h5A, good_par(8'h5A), 1'b1);
    check_state("post_reset_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
